// File: rtl/serial_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx
// Description : Oversampling receiver for the asynchronous serial frame link.
//               Frame format: idle high, start bit (0), DATA_W data bits
//               LSB first, optional parity bit, stop bit (1). Good frames land
//               in a one-deep valid/ready holding register. Bad or dropped
//               frames raise one-cycle error pulses.
// Ports       : i_clk        - clock, rising edge
//               i_rst_n      - synchronous active-low reset
//               i_rxd        - asynchronous serial line, idle high
//               o_data       - received payload, stable while o_valid
//               o_valid      - payload available
//               i_ready      - consumer accepts when o_valid & i_ready
//               o_busy       - receiver is inside a frame (state != IDLE)
//               o_parity_err - pulse: parity mismatch, frame dropped
//               o_frame_err  - pulse: stop bit sampled low, frame dropped
//               o_overrun    - pulse: good frame dropped, holding reg full
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rxd,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_busy,
   output logic              o_parity_err,
   output logic              o_frame_err,
   output logic              o_overrun
);

   // Odd bit periods are rounded down so the half-bit point is exact.
   localparam int unsigned c_cpb   = (CLKS_PER_BIT / 2) * 2;
   localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W   = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] c_half_reload = CNT_W'(c_cpb / 2 - 1);
   localparam logic [CNT_W-1:0] c_full_reload = CNT_W'(c_cpb - 1);
   localparam logic [BIT_W-1:0] c_last_bit    = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Line synchronizer
   logic              rxd_meta_q;
   logic              rxd_s_q;

   // Frame FSM
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_mis_q, par_mis_d;

   // Stop-sample stage and output stage
   logic              done_q;
   logic              ferr_q;
   logic              perr_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              perr_pulse_q;
   logic              ferr_pulse_q;
   logic              ovr_q;

   logic              w_cnt_zero;
   logic              w_par_exp;
   logic              w_stop_done;
   logic              w_good;

   assign w_cnt_zero = (cnt_q == '0);
   assign w_par_exp  = (^shift_q) ^ PARITY_ODD;
   assign w_good     = done_q & ~ferr_q & ~perr_q;

   // The synchronizer presets to the idle level so a reset never looks like
   // a start edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= i_rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_mis_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_mis_q <= par_mis_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      par_mis_d   = par_mis_q;
      w_stop_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rxd_s_q) begin
               cnt_d     = c_half_reload;
               par_mis_d = 1'b0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (w_cnt_zero) begin
               // A line that is high again at mid-start was a glitch.
               if (rxd_s_q) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = c_full_reload;
                  bit_d   = '0;
                  state_d = ST_DATA;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DATA: begin
            if (w_cnt_zero) begin
               // Shift in from the top so the first (LSB) bit ends at bit 0.
               shift_d = {rxd_s_q, shift_q[DATA_W-1:1]};
               cnt_d   = c_full_reload;
               bit_d   = bit_q + 1'b1;
               if (bit_q == c_last_bit) begin
                  state_d = PARITY_EN ? ST_PARITY : ST_STOP;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_PARITY: begin
            if (w_cnt_zero) begin
               par_mis_d = rxd_s_q ^ w_par_exp;
               cnt_d     = c_full_reload;
               state_d   = ST_STOP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STOP: begin
            // Leaving at mid-stop lets a back-to-back start bit be caught.
            if (w_cnt_zero) begin
               w_stop_done = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Stop-sample verdict, resolved one cycle later in the output stage.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         done_q <= w_stop_done;
         ferr_q <= w_stop_done & ~rxd_s_q;
         perr_q <= w_stop_done & par_mis_q;
      end
   end

   // Holding register. A delivery may coincide with the consumer taking the
   // previous word; in that case the new word replaces it without a gap.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         data_q       <= '0;
         valid_q      <= 1'b0;
         perr_pulse_q <= 1'b0;
         ferr_pulse_q <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         ferr_pulse_q <= ferr_q;
         perr_pulse_q <= perr_q & ~ferr_q;
         ovr_q        <= w_good & valid_q & ~i_ready;
         if (w_good && (!valid_q || i_ready)) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
         end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_parity_err = perr_pulse_q;
   assign o_frame_err  = ferr_pulse_q;
   assign o_overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Self-checking bench for serial_frame_rx. Two instances: one
//               with default parameters, one with even parity enabled.
//               Expected events are queued when a frame is driven and
//               popped when the matching DUT output appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

   localparam int unsigned CPB = 16;
   localparam int unsigned DW  = 8;

   localparam logic [1:0] EV_GOOD = 2'd0;
   localparam logic [1:0] EV_PERR = 2'd1;
   localparam logic [1:0] EV_FERR = 2'd2;
   localparam logic [1:0] EV_OVR  = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } ev_t;

   typedef struct {
      int unsigned sel;
      logic [7:0]  data;
      logic        par_bit;
      logic        stop_bit;
      logic [1:0]  exp_kind;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rxd0, rxd1, ready0, ready1;
   logic [7:0] data0, data1;
   logic       valid0, valid1, busy0, busy1;
   logic       perr0, perr1, ferr0, ferr1, ovr0, ovr1;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   start0 = 0, start1 = 0;
   int   rise0  = 0, rise1  = 0;
   logic pv0    = 1'b0, pv1 = 1'b0;
   int   busy_cnt;
   ev_t  q0[$], q1[$];
   vec_t tbl[9];

   serial_frame_rx u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd0),
      .o_data(data0), .o_valid(valid0), .i_ready(ready0), .o_busy(busy0),
      .o_parity_err(perr0), .o_frame_err(ferr0), .o_overrun(ovr0)
   );

   serial_frame_rx #(
      .DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
   ) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd1),
      .o_data(data1), .o_valid(valid1), .i_ready(ready1), .o_busy(busy1),
      .o_parity_err(perr1), .o_frame_err(ferr1), .o_overrun(ovr1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic observe(input int sel, input logic [1:0] kind, input logic [7:0] d);
      ev_t e;
      int  sz;
      checks++;
      sz = (sel == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         errors++;
         $display("FAIL sb%0d unexpected event: got kind %0d data %0h, required none", sel, kind, d);
      end else begin
         if (sel == 0) e = q0.pop_front();
         else          e = q1.pop_front();
         if (e.kind !== kind || (kind == EV_GOOD && e.data !== d)) begin
            errors++;
            $display("FAIL sb%0d event: got kind %0d data %0h, required kind %0d data %0h",
                     sel, kind, d, e.kind, e.data);
         end
      end
   endtask

   // Output monitor: every accepted word and every pulse is one event.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (valid0 && ready0) observe(0, EV_GOOD, data0);
         if (perr0)            observe(0, EV_PERR, 8'h00);
         if (ferr0)            observe(0, EV_FERR, 8'h00);
         if (ovr0)             observe(0, EV_OVR,  8'h00);
         if (valid1 && ready1) observe(1, EV_GOOD, data1);
         if (perr1)            observe(1, EV_PERR, 8'h00);
         if (ferr1)            observe(1, EV_FERR, 8'h00);
         if (ovr1)             observe(1, EV_OVR,  8'h00);
      end
      if (valid0 && !pv0) rise0 <= cyc;
      if (valid1 && !pv1) rise1 <= cyc;
      pv0 <= valid0;
      pv1 <= valid1;
   end

   function automatic int exp_lat(input int sel);
      return 2 + CPB / 2 + (DW + sel + 1) * CPB + 1;
   endfunction

   task automatic push_ev(input int sel, input logic [1:0] kind, input logic [7:0] d);
      ev_t e;
      e.kind = kind;
      e.data = d;
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
   endtask

   task automatic drive_bit(input int sel, input logic b);
      if (sel == 0) rxd0 = b;
      else          rxd1 = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   task automatic send(input int sel, input logic [7:0] d, input logic pb, input logic sb);
      if (sel == 0) start0 = cyc;
      else          start1 = cyc;
      drive_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
      if (sel == 1) drive_bit(sel, pb);
      drive_bit(sel, sb);
      if (sel == 0) rxd0 = 1'b1;
      else          rxd1 = 1'b1;
   endtask

   initial begin
      tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, EV_GOOD};
      tbl[1] = '{0, 8'h00, 1'b0, 1'b1, EV_GOOD};
      tbl[2] = '{0, 8'hFF, 1'b0, 1'b1, EV_GOOD};
      tbl[3] = '{1, 8'h07, 1'b1, 1'b1, EV_GOOD};
      tbl[4] = '{1, 8'h07, 1'b0, 1'b1, EV_PERR};
      tbl[5] = '{1, 8'h3C, 1'b1, 1'b0, EV_FERR};
      tbl[6] = '{1, 8'h11, 1'b0, 1'b1, EV_GOOD};
      tbl[7] = '{0, 8'h3C, 1'b0, 1'b0, EV_FERR};
      tbl[8] = '{1, 8'h80, 1'b1, 1'b1, EV_GOOD};

      rst_n  = 1'b0;
      rxd0   = 1'b1;
      rxd1   = 1'b1;
      ready0 = 1'b1;
      ready1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset valid0", {31'd0, valid0}, 0);
      chk("reset data0",  {24'd0, data0},  0);
      chk("reset busy0",  {31'd0, busy0},  0);
      chk("reset valid1", {31'd0, valid1}, 0);
      chk("reset data1",  {24'd0, data1},  0);
      chk("reset busy1",  {31'd0, busy1},  0);
      chk("reset pulses", {26'd0, perr0, ferr0, ovr0, perr1, ferr1, ovr1}, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Short low glitch while idle: START resolves it as a false start.
      busy_cnt = 0;
      rxd0 = 1'b0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (k == 4) rxd0 = 1'b1;
         if (busy0) busy_cnt++;
      end
      @(posedge clk);
      #1;
      chk("glitch busy cycles", busy_cnt, 8);
      chk("glitch busy end", {31'd0, busy0}, 0);
      chk("glitch no valid", {31'd0, valid0}, 0);

      for (int i = 0; i < 9; i++) begin
         push_ev(tbl[i].sel, tbl[i].exp_kind, tbl[i].data);
         send(tbl[i].sel, tbl[i].data, tbl[i].par_bit, tbl[i].stop_bit);
         repeat (3 * CPB) @(posedge clk);
         #1;
         if (tbl[i].exp_kind == EV_GOOD) begin
            if (tbl[i].sel == 0)
               chk($sformatf("vec%0d latency", i), rise0 - start0 - 1, exp_lat(0));
            else
               chk($sformatf("vec%0d latency", i), rise1 - start1 - 1, exp_lat(1));
         end
         chk($sformatf("vec%0d drained", i),
             (tbl[i].sel == 0) ? q0.size() : q1.size(), 0);
      end

      // Overrun: consumer stalled across two back-to-back frames.
      ready0 = 1'b0;
      push_ev(0, EV_OVR, 8'h00);
      push_ev(0, EV_GOOD, 8'h12);
      send(0, 8'h12, 1'b0, 1'b1);
      send(0, 8'h34, 1'b0, 1'b1);
      chk("ovr held data", {24'd0, data0}, 32'h12);
      chk("ovr held valid", {31'd0, valid0}, 1);
      ready0 = 1'b1;
      @(posedge clk);
      #1;
      chk("ovr accept falls", {31'd0, valid0}, 0);
      chk("ovr drained", q0.size(), 0);

      // Consumer accepts in the very cycle the second word is delivered.
      ready0 = 1'b0;
      push_ev(0, EV_GOOD, 8'h12);
      push_ev(0, EV_GOOD, 8'h34);
      send(0, 8'h12, 1'b0, 1'b1);
      fork
         send(0, 8'h34, 1'b0, 1'b1);
         begin
            repeat (exp_lat(0)) @(posedge clk);
            #1;
            ready0 = 1'b1;
            @(posedge clk);
            #1;
            chk("swap valid", {31'd0, valid0}, 1);
            chk("swap data", {24'd0, data0}, 32'h34);
            chk("swap no overrun", {31'd0, ovr0}, 0);
         end
      join
      repeat (CPB) @(posedge clk);
      #1;
      chk("swap drained", q0.size(), 0);
      chk("swap valid end", {31'd0, valid0}, 0);

      // Reset in the middle of the data bits abandons the frame.
      fork
         send(0, 8'hFF, 1'b0, 1'b1);
         begin
            repeat (4 * CPB) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            chk("midrst data0",  {24'd0, data0},  0);
            chk("midrst valid0", {31'd0, valid0}, 0);
            chk("midrst busy0",  {31'd0, busy0},  0);
            chk("midrst pulses", {29'd0, perr0, ferr0, ovr0}, 0);
            rst_n = 1'b1;
         end
      join
      repeat (2 * CPB) @(posedge clk);
      #1;
      chk("midrst no delivery", {31'd0, valid0}, 0);
      push_ev(0, EV_GOOD, 8'h5A);
      send(0, 8'h5A, 1'b0, 1'b1);
      repeat (3 * CPB) @(posedge clk);
      #1;
      chk("post-rst latency", rise0 - start0 - 1, exp_lat(0));
      chk("final q0 drained", q0.size(), 0);
      chk("final q1 drained", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receive side of the team's parameterised asynchronous serial frame link. It pairs with the existing frame transmitter.
- Frame format:
  - idle-high line;
  - one start bit (0);
  - DATA_W data bits, LSB first;
  - one optional parity bit;
  - one stop bit (1).
- The block oversamples the line and checks each frame. Good frames go into a one-deep valid/ready holding register; bad frames raise error pulses.
- It sits between a board-level serial pin and any on-chip byte/word consumer.

Parameters:
- DATA_W, int unsigned, 8 — data bits per frame; legal 5..16.
- CLKS_PER_BIT, int unsigned, 16 — clock cycles per bit period; legal >= 4; values are rounded down to even.
- PARITY_EN, bit, 1'b0 — 1 = a parity bit follows the data bits.
- PARITY_ODD, bit, 1'b0 — 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- Every parameter carries an explicit type and an explicit default value.

Ports:
- i_clk  input  1  — sole clock, rising edge.
- i_rst_n  input  1  — synchronous, active-low reset.
- i_rxd  input  1  — asynchronous serial line, idle high.
- o_data  output  DATA_W  — received payload; stable while o_valid = 1.
- o_valid  output  1  — payload available.
- i_ready  input  1  — consumer accepts the payload when o_valid & i_ready.
- o_busy  output  1  — high while any state other than IDLE is active.
- o_parity_err  output  1  — one-cycle pulse: parity mismatch, frame dropped.
- o_frame_err  output  1  — one-cycle pulse: stop bit sampled 0, frame dropped.
- o_overrun  output  1  — one-cycle pulse: good frame dropped because the holding register was full.

Behaviour:
- **Reset** (i_rst_n = 0 at a clock edge):
  - the 2-flop synchronizer on i_rxd presets to 1;
  - state = IDLE;
  - o_data = 0, o_valid = 0, o_busy = 0, all error pulses = 0;
  - bit and cycle counters = 0.
  - A reset mid-frame abandons the frame; no output is produced.
- **Synchronizer:** rxd_s is i_rxd after two flops. All decisions use rxd_s.
- **Counters:**
  - cycle counter width = $clog2(CLKS_PER_BIT);
  - bit counter width = $clog2(DATA_W + 1);
  - both wrap only by explicit reload, never by overflow.
- **IDLE:** when rxd_s = 0, load cycle counter with CLKS_PER_BIT/2 - 1 and go to START.
- **START:** count down; at 0, sample rxd_s.
  - If 1: false start, return to IDLE, no pulse.
  - If 0: reload CLKS_PER_BIT - 1, clear bit counter, go to DATA.
- **DATA:** at each count 0, shift rxd_s into the shift register MSB-side, so that the first-received bit ends at bit 0; reload; increment bit counter.
  - After the DATA_W-th sample, go to PARITY if PARITY_EN = 1, else to STOP.
- **PARITY:** at count 0, sample rxd_s.
  - Computed parity = XOR of the data bits XOR PARITY_ODD.
  - Record a mismatch flag; go to STOP.
- **STOP:** at count 0, sample rxd_s, then return to IDLE in the same cycle. This allows a back-to-back start edge half a bit period later.
  - Sample 0 → o_frame_err pulse next cycle; data dropped. Frame error takes priority over a parity error.
  - Else parity mismatch → o_parity_err pulse; data dropped.
  - Else good frame → deliver.
- **Delivery** (registered, cycle after the stop sample):
  - If o_valid = 0, or o_valid & i_ready in that same cycle: o_data ← shift register, o_valid ← 1.
  - Otherwise: o_overrun pulse; old o_data retained; o_valid stays 1.
- **Handshake:**
  - o_valid falls the cycle after o_valid & i_ready, unless a delivery happens in that same cycle, in which case o_valid stays 1 with the new data.
  - o_data never changes while o_valid = 1 and i_ready = 0.
- **Latency:** o_valid rises exactly 2 + CLKS_PER_BIT/2 + (DATA_W + PARITY_EN + 1)·CLKS_PER_BIT + 1 cycles after the first cycle i_rxd is low.
  - Example: defaults give 155 cycles.
- **Line stuck low** after a frame error: each resulting frame is a new start. Repeated o_frame_err pulses are correct behaviour.

Test Plan:
1. Defaults; send 0xA5 at 16 clk/bit with i_ready = 1 → o_valid rises 155 cycles after the start edge with o_data = 0xA5; one-cycle valid; no error pulses.
2. 4-cycle low glitch on i_rxd while idle → back to IDLE after the START sample; o_busy high for 8 cycles; no o_valid, no pulses.
3. PARITY_EN = 1, PARITY_ODD = 0; send 0x07 with parity bit 1 → o_valid, o_data = 0x07. Resend with parity bit 0 → o_parity_err pulse, o_valid stays 0.
4. Send 0x3C with stop bit forced 0 → o_frame_err pulse; no o_parity_err even with parity enabled and wrong; next frame 0x11 received correctly.
5. i_ready = 0; send 0x12 then 0x34 back-to-back → o_data = 0x12 held, o_overrun pulse at the second delivery. Raise i_ready → 0x12 accepted, o_valid falls. Repeat with i_ready = 1 exactly in the second delivery cycle → o_data becomes 0x34, no overrun.
6. Assert i_rst_n = 0 for one cycle in the middle of the DATA bits of 0xFF → all outputs 0 next cycle, no delivery. A subsequent clean frame 0x5A is received correctly.
